cajero_multi: RTL and testbench

//  Parametrised next-generation ATM controller: card insertion, N-digit PIN entry, attempt counting with warning/lock,

---
 rtl/cajero_multi_pkg.sv | 19 +
 rtl/cajero_multi_if.sv | 39 +++
 rtl/cajero_multi_pin_shift.sv | 43 ++++
 rtl/cajero_multi.sv | 180 ++++++++++++++++++
 tb/tb_cajero_multi.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cajero_multi_pkg.sv
// Shared types and constants for the cajero_multi ATM controller.
package cajero_multi_pkg;

  typedef enum logic [2:0] {
    StEsperaTarjeta,
    StRecibePin,
    StVerificaPin,
    StEsperaMonto,
    StCalcula,
    StTransaccion,
    StBloqueado
  } estado_e;

  localparam logic TransDeposito     = 1'b0;
  localparam logic TransRetiro       = 1'b1;
  localparam logic TarjetaLocal      = 1'b0;
  localparam logic TarjetaExtranjera = 1'b1;

endpackage

// File: rtl/cajero_multi_if.sv
// Front-end bus of the ATM controller: card/keypad/cash requests in, results and balance out.
interface cajero_multi_if #(
  parameter int unsigned PIN_DIGITS = 4,
  parameter int unsigned MONTO_W    = 32,
  parameter int unsigned BAL_W      = 64
);
  logic                    tarjeta_recibida;
  logic                    tipo_de_tarjeta;
  logic [4*PIN_DIGITS-1:0] pin;
  logic [3:0]              digito;
  logic                    digito_stb;
  logic                    tipo_trans;
  logic [MONTO_W-1:0]      monto;
  logic                    monto_stb;

  logic                    entregar_dinero;
  logic                    fondos_insuficientes;
  logic                    pin_incorrecto;
  logic                    advertencia;
  logic                    bloqueo;
  logic                    balance_actualizado;
  logic                    comision;
  logic                    limite_excedido;
  logic [BAL_W-1:0]        balance;

  modport master (
    output tarjeta_recibida, tipo_de_tarjeta, pin, digito, digito_stb,
    output tipo_trans, monto, monto_stb,
    input  entregar_dinero, fondos_insuficientes, pin_incorrecto, advertencia, bloqueo,
    input  balance_actualizado, comision, limite_excedido, balance
  );

  modport slave (
    input  tarjeta_recibida, tipo_de_tarjeta, pin, digito, digito_stb,
    input  tipo_trans, monto, monto_stb,
    output entregar_dinero, fondos_insuficientes, pin_incorrecto, advertencia, bloqueo,
    output balance_actualizado, comision, limite_excedido, balance
  );
endinterface

// File: rtl/cajero_multi_pin_shift.sv
// PIN digit collector: counts keypad strobes, shifts digits in MS-first, flags the last one.
module cajero_multi_pin_shift #(
  parameter int unsigned PIN_DIGITS = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic [3:0]              digito_i,
  input  logic [4*PIN_DIGITS-1:0] pin_i,
  output logic                    done_o,
  output logic                    match_o
);

  localparam int unsigned CntW = $clog2(PIN_DIGITS + 1);
  localparam int unsigned PinW = 4 * PIN_DIGITS;

  logic [CntW-1:0] cnt_q;
  logic [PinW-1:0] shift_q;
  logic            done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
    end else if (clr_i) begin
      cnt_q   <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
    end else if (en_i) begin
      shift_q <= (shift_q << 4) | PinW'(digito_i);
      cnt_q   <= cnt_q + 1'b1;
      if (cnt_q == CntW'(PIN_DIGITS - 1)) begin
        done_q <= 1'b1;
      end
    end
  end

  assign done_o  = done_q;
  assign match_o = (shift_q == pin_i);

endmodule

// File: rtl/cajero_multi.sv
// ATM controller: PIN entry with attempt lock-out, repeated deposits/withdrawals, foreign-card fee.
// Define LIMITE_RETIRO_EN to enable the per-session withdrawal cap (LIMITE_EXCEDIDO).
module cajero_multi
  import cajero_multi_pkg::*;
#(
  parameter int unsigned     PIN_DIGITS      = 4,
  parameter int unsigned     MONTO_W         = 32,
  parameter int unsigned     BAL_W           = 64,
  parameter longint unsigned BALANCE_INICIAL = 1000,
  parameter int unsigned     MAX_INTENTOS    = 3,
  parameter int unsigned     COMISION_FIJA   = 5
`ifdef LIMITE_RETIRO_EN
  ,
  parameter longint unsigned LIMITE_RETIRO   = 500
`endif
) (
  input logic           clk,
  input logic           reset,
  cajero_multi_if.slave bus
);

  localparam int unsigned IntW = $clog2(MAX_INTENTOS + 1);
  localparam int unsigned SumW = BAL_W + 1;

  estado_e            estado_q;
  logic               tipo_tarjeta_q;
  logic               tipo_trans_q;
  logic [MONTO_W-1:0] monto_q;
  logic [SumW-1:0]    suma_q;
  logic [BAL_W-1:0]   balance_q;
  logic [IntW-1:0]    intentos_q;
  logic [IntW-1:0]    intentos_sig;
  logic               entregar_q, fondos_q, pin_inc_q, adv_q, bloqueo_q;
  logic               actualizado_q, comision_q, limite_q;
  logic               pin_clr, pin_en, pin_done, pin_match;
  logic               limite_hit;

`ifdef LIMITE_RETIRO_EN
  logic [BAL_W-1:0] acum_q;
  assign limite_hit = ({1'b0, acum_q} + SumW'(monto_q)) > SumW'(LIMITE_RETIRO);
`else
  assign limite_hit = 1'b0;
`endif

  assign intentos_sig = intentos_q + 1'b1;
  assign pin_clr      = (estado_q != StRecibePin);
  assign pin_en       = (estado_q == StRecibePin) && bus.tarjeta_recibida && bus.digito_stb &&
                        !pin_done;

  cajero_multi_pin_shift #(
    .PIN_DIGITS(PIN_DIGITS)
  ) u_pin_shift (
    .clk_i   (clk),
    .rst_ni  (reset),
    .clr_i   (pin_clr),
    .en_i    (pin_en),
    .digito_i(bus.digito),
    .pin_i   (bus.pin),
    .done_o  (pin_done),
    .match_o (pin_match)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q       <= StEsperaTarjeta;
      tipo_tarjeta_q <= TarjetaLocal;
      tipo_trans_q   <= TransDeposito;
      monto_q        <= '0;
      suma_q         <= '0;
      balance_q      <= BAL_W'(BALANCE_INICIAL);
      intentos_q     <= '0;
      entregar_q     <= 1'b0;
      fondos_q       <= 1'b0;
      pin_inc_q      <= 1'b0;
      adv_q          <= 1'b0;
      bloqueo_q      <= 1'b0;
      actualizado_q  <= 1'b0;
      comision_q     <= 1'b0;
      limite_q       <= 1'b0;
`ifdef LIMITE_RETIRO_EN
      acum_q         <= '0;
`endif
    end else begin
      entregar_q    <= 1'b0;
      fondos_q      <= 1'b0;
      pin_inc_q     <= 1'b0;
      actualizado_q <= 1'b0;
      comision_q    <= 1'b0;
      limite_q      <= 1'b0;
      // Card removal aborts any session step, including strobes in the same cycle.
      if (estado_q != StBloqueado && estado_q != StEsperaTarjeta && !bus.tarjeta_recibida) begin
        estado_q <= StEsperaTarjeta;
      end else begin
        case (estado_q)
          StEsperaTarjeta: begin
            if (bus.tarjeta_recibida) begin
              tipo_tarjeta_q <= bus.tipo_de_tarjeta;
              estado_q       <= StRecibePin;
`ifdef LIMITE_RETIRO_EN
              acum_q         <= '0;
`endif
            end
          end
          StRecibePin: begin
            if (pin_done) estado_q <= StVerificaPin;
          end
          StVerificaPin: begin
            if (pin_match) begin
              intentos_q <= '0;
              adv_q      <= 1'b0;
              estado_q   <= StEsperaMonto;
            end else begin
              pin_inc_q  <= 1'b1;
              intentos_q <= intentos_sig;
              if (intentos_sig == IntW'(MAX_INTENTOS)) begin
                bloqueo_q <= 1'b1;
                adv_q     <= 1'b0;
                estado_q  <= StBloqueado;
              end else begin
                if (intentos_sig == IntW'(MAX_INTENTOS - 1)) adv_q <= 1'b1;
                estado_q <= StRecibePin;
              end
            end
          end
          StEsperaMonto: begin
            if (bus.monto_stb) begin
              monto_q      <= bus.monto;
              tipo_trans_q <= bus.tipo_trans;
              estado_q     <= StCalcula;
            end
          end
          StCalcula: begin
            // Deposit: widened sum for saturation; withdrawal: amount plus fee.
            if (tipo_trans_q == TransDeposito) begin
              suma_q <= {1'b0, balance_q} + SumW'(monto_q);
            end else begin
              suma_q <= SumW'(monto_q) +
                        ((tipo_tarjeta_q == TarjetaExtranjera) ? SumW'(COMISION_FIJA) : '0);
            end
            estado_q <= StTransaccion;
          end
          StTransaccion: begin
            if (tipo_trans_q == TransRetiro) begin
              if (limite_hit) begin
                limite_q <= 1'b1;
              end else if (suma_q > {1'b0, balance_q}) begin
                fondos_q <= 1'b1;
              end else begin
                balance_q     <= balance_q - suma_q[BAL_W-1:0];
                entregar_q    <= 1'b1;
                actualizado_q <= 1'b1;
                comision_q    <= (tipo_tarjeta_q == TarjetaExtranjera) && (COMISION_FIJA != 0);
`ifdef LIMITE_RETIRO_EN
                acum_q        <= acum_q + BAL_W'(monto_q);
`endif
              end
            end else begin
              balance_q     <= suma_q[BAL_W] ? '1 : suma_q[BAL_W-1:0];
              actualizado_q <= 1'b1;
            end
            estado_q <= StEsperaMonto;
          end
          StBloqueado: estado_q <= StBloqueado;
          default:     estado_q <= StEsperaTarjeta;
        endcase
      end
    end
  end

  assign bus.entregar_dinero      = entregar_q;
  assign bus.fondos_insuficientes = fondos_q;
  assign bus.pin_incorrecto       = pin_inc_q;
  assign bus.advertencia          = adv_q;
  assign bus.bloqueo              = bloqueo_q;
  assign bus.balance_actualizado  = actualizado_q;
  assign bus.comision             = comision_q;
  assign bus.limite_excedido      = limite_q;
  assign bus.balance              = balance_q;

endmodule

// File: tb/tb_cajero_multi.sv
// Bench for cajero_multi: directed scenarios plus randomized sessions against a transaction-level model.
module tb_cajero_multi;

  localparam int unsigned FEE     = 5;
  localparam int unsigned MAX_INT = 3;

  typedef struct packed {
    logic        ent, fon, pinc, act, com, lim, adv, bloq;
    logic [63:0] bal;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  cajero_multi_if #(.PIN_DIGITS(4), .MONTO_W(32), .BAL_W(64)) bus ();

  cajero_multi #(
    .PIN_DIGITS     (4),
    .MONTO_W        (32),
    .BAL_W          (64),
    .BALANCE_INICIAL(1000),
    .MAX_INTENTOS   (MAX_INT),
    .COMISION_FIJA  (FEE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state: what the account/session must look like after each accepted request.
  logic [63:0] m_bal = 64'd1000;
  int          m_int = 0;
  bit          m_adv = 0, m_bloq = 0, m_foreign = 0;
  logic [64:0] m_acc = '0;

  // Expected output values currently presented by the DUT.
  logic [63:0] x_bal = 64'd1000;
  bit          x_adv = 0, x_bloq = 0;
  ev_t         sched [int];

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic void sched_ev(bit ent, bit fon, bit pinc, bit act, bit com, bit lim);
    ev_t e;
    e = '{ent: ent, fon: fon, pinc: pinc, act: act, com: com, lim: lim,
          adv: m_adv, bloq: m_bloq, bal: m_bal};
    sched[cyc + 3] = e;
  endfunction

  always @(negedge clk) begin : cmp
    ev_t e;
    e = '0;
    if (sched.exists(cyc)) begin
      e = sched[cyc];
      sched.delete(cyc);
      x_adv  = e.adv;
      x_bloq = e.bloq;
      x_bal  = e.bal;
    end
    check("entregar_dinero",      64'(bus.entregar_dinero),      64'(e.ent));
    check("fondos_insuficientes", 64'(bus.fondos_insuficientes), 64'(e.fon));
    check("pin_incorrecto",       64'(bus.pin_incorrecto),       64'(e.pinc));
    check("balance_actualizado",  64'(bus.balance_actualizado),  64'(e.act));
    check("comision",             64'(bus.comision),             64'(e.com));
    check("limite_excedido",      64'(bus.limite_excedido),      64'(e.lim));
    check("advertencia",          64'(bus.advertencia),          64'(x_adv));
    check("bloqueo",              64'(bus.bloqueo),              64'(x_bloq));
    check("balance",              bus.balance,                   x_bal);
  end

  function automatic void model_pin(logic [15:0] code);
    if (code == 16'h1234) begin
      m_int = 0;
      m_adv = 0;
      sched_ev(0, 0, 0, 0, 0, 0);
    end else begin
      m_int++;
      if (m_int == MAX_INT) begin
        m_bloq = 1;
        m_adv  = 0;
      end else if (m_int == MAX_INT - 1) begin
        m_adv = 1;
      end
      sched_ev(0, 0, 1, 0, 0, 0);
    end
  endfunction

  function automatic void model_trans(bit retiro, logic [31:0] amt);
    logic [64:0] s;
    if (!retiro) begin
      s     = {1'b0, m_bal} + 65'(amt);
      m_bal = s[64] ? '1 : s[63:0];
      sched_ev(0, 0, 0, 1, 0, 0);
      return;
    end
`ifdef LIMITE_RETIRO_EN
    if (m_acc + 65'(amt) > 65'd500) begin
      sched_ev(0, 0, 0, 0, 0, 1);
      return;
    end
`endif
    s = 65'(amt) + (m_foreign ? 65'(FEE) : 65'd0);
    if (s > {1'b0, m_bal}) begin
      sched_ev(0, 1, 0, 0, 0, 0);
    end else begin
      m_bal = m_bal - s[63:0];
      m_acc = m_acc + 65'(amt);
      sched_ev(1, 0, 0, 1, m_foreign && FEE != 0, 0);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.tarjeta_recibida = 1'b0;
    bus.digito_stb = 1'b0;
    bus.monto_stb = 1'b0;
    sched.delete();
    m_bal = 64'd1000; m_int = 0; m_adv = 0; m_bloq = 0; m_acc = '0;
    x_bal = 64'd1000; x_adv = 0; x_bloq = 0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic insert(bit foreign);
    bus.tarjeta_recibida = 1'b1;
    bus.tipo_de_tarjeta  = foreign;
    m_foreign = foreign;
    m_acc     = '0;
    tick();
    bus.tipo_de_tarjeta = 1'($urandom);
  endtask

  task automatic remove(bit with_stb);
    bus.tarjeta_recibida = 1'b0;
    if (with_stb) begin
      bus.digito_stb = 1'b1;
      bus.monto_stb  = 1'b1;
    end
    tick();
    bus.digito_stb = 1'b0;
    bus.monto_stb  = 1'b0;
  endtask

  task automatic enter_pin(logic [15:0] code, bit gaps);
    for (int i = 0; i < 4; i++) begin
      bus.digito     = code[15-4*i -: 4];
      bus.digito_stb = 1'b1;
      if (i == 3) model_pin(code);
      tick();
      bus.digito_stb = 1'b0;
      if (gaps && i < 3) repeat ($urandom_range(0, 2)) tick();
    end
    tick();
    tick();
  endtask

  task automatic trans(bit retiro, logic [31:0] amt);
    bus.tipo_trans = retiro;
    bus.monto      = amt;
    bus.monto_stb  = 1'b1;
    model_trans(retiro, amt);
    tick();
    bus.monto_stb  = 1'b0;
    bus.monto      = $urandom;
    bus.tipo_trans = 1'($urandom);
    tick();
    tick();
  endtask

  task automatic blocked_noise();
    for (int i = 0; i < 8; i++) begin
      bus.tarjeta_recibida = 1'($urandom);
      bus.digito_stb       = 1'($urandom);
      bus.digito           = 4'($urandom);
      bus.monto_stb        = 1'($urandom);
      bus.monto            = 32'($urandom_range(0, 100));
      tick();
    end
    bus.digito_stb = 1'b0;
    bus.monto_stb  = 1'b0;
  endtask

  task automatic random_session();
    bit          done;
    int          r;
    logic [15:0] code;
    logic [31:0] amt;
    bit          retiro;
    insert(1'($urandom_range(0, 1)));
    if ($urandom_range(0, 3) == 0) begin
      bus.monto_stb = 1'b1;
      tick();
      bus.monto_stb = 1'b0;
    end
    done = 0;
    while (!done) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        for (int i = 0; i < 2; i++) begin
          bus.digito = 4'($urandom);
          bus.digito_stb = 1'b1;
          tick();
          bus.digito_stb = 1'b0;
        end
        remove(0);
        done = 1;
      end else if (r < 4) begin
        code = 16'($urandom);
        if (code == 16'h1234) code = 16'h1235;
        enter_pin(code, 1);
        if (m_bloq) begin
          blocked_noise();
          done = 1;
        end else if ($urandom_range(0, 2) == 0) begin
          remove(0);
          done = 1;
        end
      end else begin
        enter_pin(16'h1234, 1);
        repeat ($urandom_range(1, 4)) begin
          if ($urandom_range(0, 3) == 0) begin
            bus.digito_stb = 1'b1;
            tick();
            bus.digito_stb = 1'b0;
          end
          retiro = 1'($urandom);
          r = $urandom_range(0, 3);
          if (!retiro) amt = 32'($urandom_range(0, 500));
          else if (r == 0) amt = 32'(m_bal) - (m_foreign ? 32'(FEE) : 32'd0);
          else if (r == 1) amt = 32'(m_bal) + 32'd1 - (m_foreign ? 32'(FEE) : 32'd0);
          else amt = 32'($urandom_range(0, 600));
          trans(retiro, amt);
        end
        remove(1'($urandom_range(0, 1)));
        done = 1;
      end
    end
  endtask

  initial begin
    bus.pin = 16'h1234;
    bus.digito = '0;
    bus.tipo_de_tarjeta = 1'b0;
    bus.tipo_trans = 1'b0;
    bus.monto = '0;
    do_reset();
    check("reset_balance", bus.balance, 64'd1000);
    check("reset_bloqueo", 64'(bus.bloqueo), 64'd0);

    // Local card, withdraw 200.
    insert(0);
    enter_pin(16'h1234, 0);
    trans(1, 200);
    check("lit_local_retiro", bus.balance, 64'd800);
    remove(0);

    // Foreign card: fee on withdrawal only.
    do_reset();
    insert(1);
    enter_pin(16'h1234, 0);
    trans(1, 100);
    check("lit_foreign_retiro", bus.balance, 64'd895);
    trans(0, 50);
    check("lit_foreign_deposito", bus.balance, 64'd945);
    remove(0);

    // Three wrong PINs lock the machine.
    do_reset();
    insert(0);
    enter_pin(16'h1235, 0);
    enter_pin(16'h1235, 0);
    check("lit_advertencia", 64'(bus.advertencia), 64'd1);
    enter_pin(16'h1235, 0);
    check("lit_bloqueo", 64'(bus.bloqueo), 64'd1);
    blocked_noise();
    check("lit_bloqueo_sticky", 64'(bus.bloqueo), 64'd1);

    // Attempts survive card removal.
    do_reset();
    insert(0);
    enter_pin(16'h1235, 0);
    remove(0);
    insert(0);
    enter_pin(16'h9999, 0);
    enter_pin(16'h1235, 0);
    check("lit_bloqueo_persist", 64'(bus.bloqueo), 64'd1);

    // Funds boundary with fee.
    do_reset();
    insert(1);
    enter_pin(16'h1234, 0);
    trans(1, 996);
    check("lit_fondos_unchanged", bus.balance, 64'd1000);
    trans(1, 995);
    check("lit_fondos_exact", bus.balance, 64'd0);
    remove(0);

`ifdef LIMITE_RETIRO_EN
    do_reset();
    insert(0);
    enter_pin(16'h1234, 0);
    trans(1, 300);
    trans(1, 250);
    check("lit_limite", bus.balance, 64'd700);
    remove(0);
    insert(0);
    enter_pin(16'h1234, 0);
    trans(1, 250);
    check("lit_limite_new_session", bus.balance, 64'd450);
    remove(0);
`endif

    do_reset();
    for (int s = 0; s < 80; s++) begin
      if (m_bloq) do_reset();
      random_session();
    end

    repeat (5) tick();
    check("pending_events", 64'(sched.num()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
